// File: rtl/bcd_convert_seq_if.sv
// Operand/result handshake bundle for bcd_convert_seq: valid/ready on the
// operand side and on the result side, plus the operand and result buses.
interface bcd_convert_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  mode;
    logic [WIDTH-1:0]      bin_in;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [WIDTH-1:0]      bin_out;
    logic                  err;

    // Front end / consumer side.
    modport master (
        output in_valid, mode, bin_in, bcd_in, out_ready,
        input  in_ready, out_valid, bcd_out, bin_out, err
    );

    // Converter side.
    modport slave (
        input  in_valid, mode, bin_in, bcd_in, out_ready,
        output in_ready, out_valid, bcd_out, bin_out, err
    );
endinterface

// File: rtl/bcd_convert_seq.sv
// Sequential binary<->BCD converter: double dabble (mode 0, one bit/cycle) or
// x10 accumulate (mode 1, one digit/cycle). Optional macro BCD_DIGIT_CHECK_EN.
module bcd_convert_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    bcd_convert_seq_if.slave bus
);
    localparam int BCD_W     = 4 * DIGITS;
    localparam int STEPS_MAX = (WIDTH > DIGITS) ? WIDTH : DIGITS;
    localparam int CNT_W     = $clog2(STEPS_MAX + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;
    logic [WIDTH-1:0] bin_op;
    logic [BCD_W-1:0] bcd_op;
    logic [WIDTH-1:0] bin_sh;
    logic [BCD_W-1:0] bcd_sh;
    logic [BCD_W-1:0] acc;

    logic [BCD_W-1:0] bcd_out_q;
    logic [WIDTH-1:0] bin_out_q;
    logic             err_q;

    // Adds 3 to every digit that is 5 or more, ahead of the left shift.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        // NOTE: r takes a full default before the loop so no path leaves it unassigned.
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    logic [BCD_W-1:0] dd_adj;
    logic [BCD_W-1:0] dd_bcd_next;
    logic [WIDTH-1:0] dd_bin_next;
    logic [3:0]       digit;
    logic [BCD_W-1:0] acc_next;
    logic [BCD_W-1:0] digit_sh_next;
    logic             ovf;
    logic             mode1_err;
    logic             last_step;

    assign dd_adj      = add3_digits(bcd_sh);
    assign dd_bcd_next = (dd_adj << 1) | BCD_W'(bin_sh[WIDTH-1]);
    assign dd_bin_next = bin_sh << 1;

    // Mode 1 reuses bcd_sh as a digit shifter, most significant digit first.
    assign digit         = bcd_sh[BCD_W-1 -: 4];
    assign acc_next      = (acc << 3) + (acc << 1) + BCD_W'(digit);
    assign digit_sh_next = bcd_sh << 4;
    assign ovf           = |acc_next[BCD_W-1:WIDTH];
    assign last_step     = (cnt == CNT_W'(1));

`ifdef BCD_DIGIT_CHECK_EN
    logic digit_bad;

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_bad <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            digit_bad <= has_bad_digit(bus.bcd_in);
        end
    end

    assign mode1_err = ovf | digit_bad;
`else
    assign mode1_err = ovf;
`endif

    always_ff @(posedge clk) begin
        // NOTE: state updates use <= so every register samples pre-edge values.
        if (rst) begin
            // NOTE: the working registers are reset too; this keeps the echo outputs deterministic.
            state     <= IDLE;
            cnt       <= '0;
            mode_q    <= 1'b0;
            bin_op    <= '0;
            bcd_op    <= '0;
            bin_sh    <= '0;
            bcd_sh    <= '0;
            acc       <= '0;
            bcd_out_q <= '0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mode_q <= bus.mode;
                        bin_op <= bus.bin_in;
                        bcd_op <= bus.bcd_in;
                        acc    <= '0;
                        bin_sh <= bus.bin_in;
                        if (bus.mode) begin
                            bcd_sh <= bus.bcd_in;
                            cnt    <= CNT_W'(DIGITS);
                        end else begin
                            bcd_sh <= '0;
                            cnt    <= CNT_W'(WIDTH);
                        end
                        state <= CONV;
                    end
                end

                CONV: begin
                    cnt <= cnt - CNT_W'(1);
                    if (mode_q) begin
                        acc    <= acc_next;
                        bcd_sh <= digit_sh_next;
                    end else begin
                        bcd_sh <= dd_bcd_next;
                        bin_sh <= dd_bin_next;
                    end

                    // Results are published only here, so they hold between operations.
                    if (last_step) begin
                        state <= DONE;
                        if (mode_q) begin
                            bcd_out_q <= bcd_op;
                            bin_out_q <= acc_next[WIDTH-1:0];
                            err_q     <= mode1_err;
                        end else begin
                            bcd_out_q <= dd_bcd_next;
                            bin_out_q <= bin_op;
                            err_q     <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.bcd_out   = bcd_out_q;
    assign bus.bin_out   = bin_out_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_bcd_convert_seq.sv
// Directed bench for bcd_convert_seq (WIDTH=16, DIGITS=5): both modes, latency,
// overflow, invalid digit, backpressure and mid-conversion reset.
module tb_bcd_convert_seq;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    bcd_convert_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bcd_convert_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the accept edge.
    task automatic start_op(input string tag, input logic m, input logic [15:0] b,
                            input logic [19:0] d);
        bus.mode     = m;
        bus.bin_in   = b;
        bus.bcd_in   = d;
        bus.in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid; scrambles inputs meanwhile.
    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            bus.bin_in   = 16'($urandom);
            bus.bcd_in   = 20'($urandom);
            bus.mode     = 1'($urandom);
            bus.in_valid = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_rel_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_rel_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic m, input logic [15:0] b,
                         input logic [19:0] d, input int exp_lat, input logic [19:0] exp_bcd,
                         input logic [15:0] exp_bin, input logic exp_err, input bit rel);
        int lat;
        start_op(tag, m, b, d);
        wait_done(lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_bcd_out"}, 32'(bus.bcd_out), 32'(exp_bcd));
        check({tag, "_bin_out"}, 32'(bus.bin_out), 32'(exp_bin));
        check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        check({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
        if (rel) release_result(tag);
    endtask

    initial begin
        int  vcount;
        logic exp_digit_err;

`ifdef BCD_DIGIT_CHECK_EN
        exp_digit_err = 1'b1;
`else
        exp_digit_err = 1'b0;
`endif

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mode      = 1'b0;
        bus.bin_in    = '0;
        bus.bcd_in    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_bcd_out", 32'(bus.bcd_out), 32'd0);
        check("rst_bin_out", 32'(bus.bin_out), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);

        do_op("b2d_max", 1'b0, 16'd65535, 20'h0, WIDTH, 20'h65535, 16'd65535, 1'b0, 1'b1);
        do_op("b2d_zero", 1'b0, 16'd0, 20'h0, WIDTH, 20'h00000, 16'd0, 1'b0, 1'b1);
        do_op("d2b_12345", 1'b1, 16'h0, 20'h12345, DIGITS, 20'h12345, 16'h3039, 1'b0, 1'b1);
        do_op("d2b_ovf", 1'b1, 16'h0, 20'h99999, DIGITS, 20'h99999, 16'h869F, 1'b1, 1'b1);
        do_op("d2b_bad", 1'b1, 16'h0, 20'h1A345, DIGITS, 20'h1A345, 16'h4F79, exp_digit_err, 1'b0);

        // Result held under backpressure while operand pulses are ignored.
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.mode     = 1'b0;
            bus.bin_in   = 16'(i + 7);
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_bin_out", 32'(bus.bin_out), 32'h4F79);
            check("bp_bcd_out", 32'(bus.bcd_out), 32'h1A345);
        end
        bus.in_valid = 1'b0;
        release_result("bp");

        // Reset four cycles into a conversion aborts it.
        start_op("abort", 1'b0, 16'd9999, 20'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_bcd_out", 32'(bus.bcd_out), 32'd0);
        check("abort_bin_out", 32'(bus.bin_out), 32'd0);
        check("abort_err", 32'(bus.err), 32'd0);
        vcount = 0;
        repeat (25) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid === 1'b1) vcount++;
        end
        check("abort_no_valid", 32'(vcount), 32'd0);

        do_op("b2d_1234", 1'b0, 16'd1234, 20'h0, WIDTH, 20'h01234, 16'd1234, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
